memlcd_scan_engine: RTL and testbench
=====================================

Name: memlcd_scan_engine

Overview:
- Parametrised timing and data engine for colour memory-in-pixel LCD panels.
- Consumes packed pixel words from the SPI RX FIFO through a valid/ready stream.
- Generates the full gate-side sequence (GSP/GCK/GEN) and source-side sequence (BSP/BCK/RGB), plus the VCOM/VA/VB toggler.
- Sits between the RX FIFO and the panel pads. Supports any panel geometry, pixels per BCK edge and colour depth, and adds underrun detection.

Parameters:
- H_PIXELS, 176: pixels per line; must be a multiple of PIX_PER_CLK.
- V_LINES, 176: lines per frame.
- PIX_PER_CLK, 2: pixels transferred per BCK edge.
- COLOR_BITS, 3: bits per pixel.
- BCK_DIV, 8: i_clk cycles per tick (BCK half-period); must be ≥ 2.
- GEN_TICKS, 2: ticks o_gen is held high per line.
- VCOM_DIV, 1000000: i_clk cycles per VCOM half-period.

Ports:
- i_clk, input, 1: system clock.
- i_reset, input, 1: reset.
- i_frame_start, input, 1: one-cycle request to scan a frame.
- i_vcom_en, input, 1: level enable for the VCOM toggler.
- i_pix_data, input, PIX_PER_CLK*COLOR_BITS: packed pixel word, pixel 0 in the LSBs.
- i_pix_valid, input, 1: pixel word valid.
- o_pix_ready, output, 1: engine accepts the word this cycle.
- o_busy, output, 1: frame in progress.
- o_frame_done, output, 1: one-cycle pulse at end of frame.
- o_underrun, output, 1: sticky; data was missing when needed.
- o_gsp, o_gck, o_gen, o_bsp, o_bck, output, 1 each: panel timing.
- o_rgb, output, PIX_PER_CLK*COLOR_BITS: panel pixel data.
- o_vcom, o_va, o_vb, output, 1 each: panel common drive.

Behaviour:
- Clock and reset: one clock, i_clk. i_reset is asynchronous and active-high.
- Reset values: every output is 0. State IDLE, counters cleared.
- Tick prescaler:
  - Counts 0..BCK_DIV-1 while o_busy=1. A tick is the cycle where the count equals BCK_DIV-1. All panel outputs update only on ticks.
  - The prescaler is cleared on frame start.
- Frame start:
  - In IDLE, i_frame_start=1 sets o_busy=1 on the next edge and enters GSP.
  - i_frame_start while busy is ignored.
  - Frame start clears o_underrun.
- FSM states: IDLE, GSP, BSP, SHIFT, GEN, END.
- GSP:
  - o_gsp=1 on entry.
  - At tick 1, o_gck toggles.
  - At tick 2, o_gsp=0 and the FSM goes to BSP. Line counter = 0.
- BSP: o_bsp=1 for 1 tick, then SHIFT.
- SHIFT (W = H_PIXELS/PIX_PER_CLK words per line):
  - o_pix_ready=1 exactly on tick cycles.
  - Each accepted word (valid&&ready) is registered to o_rgb, and o_bck toggles on the same edge.
  - o_bsp clears on the first accepted word.
  - If i_pix_valid=0 on a tick, the prescaler freezes at terminal count, o_pix_ready stays high, all outputs hold, and o_underrun is set on the first stalled cycle. Operation resumes on the cycle valid rises.
  - After W words plus one further tick, go to GEN.
- GEN:
  - o_gen=1 for GEN_TICKS ticks, then 0.
  - On the same tick, o_gck toggles and the line counter increments.
  - If the line counter equals V_LINES, go to END; otherwise go to BSP.
- END:
  - On the next tick: o_gck, o_bck and o_rgb are forced to 0, o_busy=0, o_frame_done=1 for one cycle, then IDLE.
  - A full frame therefore has V_LINES+1 GCK toggles, plus one forced return to 0 if o_gck was high.
- Latency: o_gsp rises 1 cycle after i_frame_start.
- VCOM toggler:
  - Independent of the FSM.
  - While i_vcom_en=1, a counter wraps at VCOM_DIV-1 and toggles o_vcom on wrap.
  - o_va = ~o_vcom and o_vb = o_vcom while enabled.
  - While i_vcom_en=0, the counter is cleared and o_vcom, o_va, o_vb are all 0.
  - The first toggle occurs VCOM_DIV cycles after enable rises.
- Mid-frame reset: all outputs return to 0 immediately. FIFO words already consumed are lost, and no o_frame_done is issued.
- Words presented while not in SHIFT are not accepted (o_pix_ready=0).

Optional Feature:
- Macro: MEMLCD_PARTIAL_EN.
- With the macro defined, the block adds inputs i_first_line and i_num_lines (both $clog2(V_LINES+1) bits), latched at frame start.
  - Lines below i_first_line are skipped: one GCK toggle per tick, with no BSP, no data and no GEN.
  - After i_num_lines scanned lines, the FSM goes straight to END.
  - i_num_lines=0 or i_first_line ≥ V_LINES produces GSP, then END only.
  - A range exceeding V_LINES is clipped at V_LINES.
- Without the macro: no extra ports; every frame scans all V_LINES lines.

Test Plan (H_PIXELS=4, PIX_PER_CLK=2, V_LINES=2, BCK_DIV=2, GEN_TICKS=1, VCOM_DIV=4):
1. Reset mid-SHIFT with o_bck=1 and o_rgb=6'h2A -> all outputs read 0 in the same cycle; after release, o_busy=0.
2. Full frame with i_pix_valid held 1 and words 01,02,03,04 -> exactly 4 words accepted; o_rgb sequence 01,02 | 03,04; 3 GCK toggles then forced 0; o_frame_done pulses once; o_underrun=0.
3. Same frame with valid dropped for 5 cycles before word 2 -> outputs frozen during the gap; o_underrun=1; frame completes with correct data; next i_frame_start clears o_underrun.
4. i_frame_start pulsed again while o_busy=1 -> ignored: only one o_frame_done pulse, GCK count unchanged.
5. i_vcom_en=1 for 20 cycles -> o_vcom toggles every 4 cycles (5 toggles), o_va is always the inverse of o_vcom; enable low -> all three are 0 on the next cycle.
6. With MEMLCD_PARTIAL_EN, i_first_line=1, i_num_lines=1 -> line 0 gets a GCK toggle only; 2 words accepted for line 1; one GEN pulse; then END.

Source files
------------

// File: rtl/memlcd_scan_engine.sv
// Gate/source timing and pixel data engine for colour memory-in-pixel LCD panels.
// Define MEMLCD_PARTIAL_EN to add partial-frame (first line / line count) scanning.
module memlcd_scan_engine #(
  parameter int H_PIXELS    = 176,
  parameter int V_LINES     = 176,
  parameter int PIX_PER_CLK = 2,
  parameter int COLOR_BITS  = 3,
  parameter int BCK_DIV     = 8,
  parameter int GEN_TICKS   = 2,
  parameter int VCOM_DIV    = 1000000
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_frame_start,
  input  logic                              i_vcom_en,
`ifdef MEMLCD_PARTIAL_EN
  input  logic [$clog2(V_LINES+1)-1:0]      i_first_line,
  input  logic [$clog2(V_LINES+1)-1:0]      i_num_lines,
`endif
  input  logic [PIX_PER_CLK*COLOR_BITS-1:0] i_pix_data,
  input  logic                              i_pix_valid,
  output logic                              o_pix_ready,
  output logic                              o_busy,
  output logic                              o_frame_done,
  output logic                              o_underrun,
  output logic                              o_gsp,
  output logic                              o_gck,
  output logic                              o_gen,
  output logic                              o_bsp,
  output logic                              o_bck,
  output logic [PIX_PER_CLK*COLOR_BITS-1:0] o_rgb,
  output logic                              o_vcom,
  output logic                              o_va,
  output logic                              o_vb
);
  localparam int W  = H_PIXELS / PIX_PER_CLK;
  localparam int LW = $clog2(V_LINES + 1);
  localparam int PW = $clog2(BCK_DIV);
  localparam int WW = $clog2(W + 1);
  localparam int SW = $clog2(GEN_TICKS + 2);
  localparam int VW = $clog2(VCOM_DIV + 1);

  typedef enum logic [2:0] {S_IDLE, S_GSP, S_BSP, S_SHIFT, S_GEN, S_END} state_t;
  state_t state_reg, state_next;

  logic [PW-1:0] pre_reg;
  logic [LW-1:0] line_reg;
  logic [WW-1:0] word_reg;
  logic [SW-1:0] sub_reg;
  logic          tick, start_ok, accept, stall, skip_line, range_empty, last_line_hit;
  logic [LW:0]   last_line;

`ifdef MEMLCD_PARTIAL_EN
  logic [LW-1:0] first_reg;
  logic [LW:0]   last_reg;
  logic          empty_reg;
  logic [LW:0]   range_sum;
  assign range_sum = {1'b0, i_first_line} + {1'b0, i_num_lines};
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      first_reg <= '0;
      last_reg  <= '0;
      empty_reg <= 1'b0;
    end else if (start_ok) begin
      first_reg <= i_first_line;
      last_reg  <= (range_sum > (LW+1)'(V_LINES)) ? (LW+1)'(V_LINES) : range_sum;
      empty_reg <= (i_num_lines == '0) || (i_first_line >= LW'(V_LINES));
    end
  end
  assign skip_line   = line_reg < first_reg;
  assign range_empty = empty_reg;
  assign last_line   = last_reg;
`else
  assign skip_line   = 1'b0;
  assign range_empty = 1'b0;
  assign last_line   = (LW+1)'(V_LINES);
`endif

  assign tick          = o_busy && (pre_reg == PW'(BCK_DIV - 1));
  assign start_ok      = (state_reg == S_IDLE) && i_frame_start;
  assign last_line_hit = ((LW+1)'(line_reg) + (LW+1)'(1)) == last_line;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_ok) state_next = S_GSP;
      S_GSP:   if (tick && sub_reg == SW'(1)) state_next = range_empty ? S_END : S_BSP;
      S_BSP:   if (tick && !skip_line) state_next = S_SHIFT;
      S_SHIFT: if (tick && word_reg == WW'(W)) state_next = S_GEN;
      S_GEN:   if (tick && sub_reg == SW'(GEN_TICKS - 1)) state_next = last_line_hit ? S_END : S_BSP;
      S_END:   if (tick) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Stream handshake: ready on every tick while words of the line remain
  always_comb begin
    o_pix_ready = (state_reg == S_SHIFT) && tick && (word_reg != WW'(W));
    accept      = o_pix_ready && i_pix_valid;
    stall       = o_pix_ready && !i_pix_valid;
  end

  // A stall holds the prescaler at terminal count so tick stays asserted
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                  pre_reg <= '0;
    else if (start_ok || !o_busy) pre_reg <= '0;
    else if (!stall)              pre_reg <= tick ? '0 : pre_reg + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_busy <= 1'b0; o_frame_done <= 1'b0; o_underrun <= 1'b0;
      o_gsp <= 1'b0; o_gck <= 1'b0; o_gen <= 1'b0; o_bsp <= 1'b0; o_bck <= 1'b0;
      o_rgb <= '0; line_reg <= '0; word_reg <= '0; sub_reg <= '0;
    end else begin
      o_frame_done <= 1'b0;
      if (start_ok) begin
        o_busy     <= 1'b1;
        o_gsp      <= 1'b1;
        o_underrun <= 1'b0;
        sub_reg    <= '0;
      end
      if (stall) o_underrun <= 1'b1;
      if (tick) begin
        case (state_reg)
          S_GSP: begin
            if (sub_reg == '0) begin
              o_gck   <= ~o_gck;
              sub_reg <= SW'(1);
            end else begin
              o_gsp    <= 1'b0;
              line_reg <= '0;
            end
          end
          S_BSP: begin
            if (skip_line) begin
              o_gck    <= ~o_gck;
              line_reg <= line_reg + 1'b1;
            end else begin
              o_bsp    <= 1'b1;
              word_reg <= '0;
            end
          end
          S_SHIFT: begin
            if (accept) begin
              o_rgb    <= i_pix_data;
              o_bck    <= ~o_bck;
              o_bsp    <= 1'b0;
              word_reg <= word_reg + 1'b1;
            end else if (word_reg == WW'(W)) begin
              o_gen   <= 1'b1;
              sub_reg <= '0;
            end
          end
          S_GEN: begin
            if (sub_reg == SW'(GEN_TICKS - 1)) begin
              o_gen    <= 1'b0;
              o_gck    <= ~o_gck;
              line_reg <= line_reg + 1'b1;
            end else begin
              sub_reg <= sub_reg + 1'b1;
            end
          end
          S_END: begin
            o_gck        <= 1'b0;
            o_bck        <= 1'b0;
            o_rgb        <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // VCOM toggler, free-running and independent of the scan FSM
  logic [VW-1:0] vcnt_reg;
  logic          vcom_next;
  assign vcom_next = (vcnt_reg == VW'(VCOM_DIV - 1)) ? ~o_vcom : o_vcom;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset || !i_vcom_en) begin
      vcnt_reg <= '0; o_vcom <= 1'b0; o_va <= 1'b0; o_vb <= 1'b0;
    end else begin
      vcnt_reg <= (vcnt_reg == VW'(VCOM_DIV - 1)) ? '0 : vcnt_reg + 1'b1;
      o_vcom   <= vcom_next;
      o_va     <= ~vcom_next;
      o_vb     <= vcom_next;
    end
  end
endmodule

// File: tb/tb_memlcd_scan_engine.sv
// Scoreboard bench for memlcd_scan_engine on a 4x2 panel, two pixels per BCK edge.
`timescale 1ns/1ps
module tb_memlcd_scan_engine;
  localparam int V_LINES = 2;
  localparam int LW      = $clog2(V_LINES + 1);

  logic       i_clk = 1'b0, i_reset = 1'b1, i_frame_start = 1'b0, i_vcom_en = 1'b0;
  logic [5:0] i_pix_data = '0;
  logic       i_pix_valid = 1'b0;
  logic       o_pix_ready, o_busy, o_frame_done, o_underrun;
  logic       o_gsp, o_gck, o_gen, o_bsp, o_bck, o_vcom, o_va, o_vb;
  logic [5:0] o_rgb;
`ifdef MEMLCD_PARTIAL_EN
  logic [LW-1:0] i_first_line = '0, i_num_lines = LW'(V_LINES);
`endif

  memlcd_scan_engine #(
    .H_PIXELS(4), .V_LINES(V_LINES), .PIX_PER_CLK(2), .COLOR_BITS(3),
    .BCK_DIV(2), .GEN_TICKS(1), .VCOM_DIV(4)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_frame_start(i_frame_start), .i_vcom_en(i_vcom_en),
`ifdef MEMLCD_PARTIAL_EN
    .i_first_line(i_first_line), .i_num_lines(i_num_lines),
`endif
    .i_pix_data(i_pix_data), .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_underrun(o_underrun),
    .o_gsp(o_gsp), .o_gck(o_gck), .o_gen(o_gen), .o_bsp(o_bsp), .o_bck(o_bck),
    .o_rgb(o_rgb), .o_vcom(o_vcom), .o_va(o_va), .o_vb(o_vb)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0, miscompares = 0;
  int gck_changes = 0, gen_pulses = 0, done_pulses = 0, accepts = 0;
  logic bck_prev = 1'b0, gck_prev = 1'b0, gen_prev = 1'b0;
  logic [5:0] exp_q[$];
  logic [5:0] exp_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [17:0] all_outputs();
    return {o_busy, o_frame_done, o_underrun, o_gsp, o_gck, o_gen, o_bsp, o_bck,
            o_pix_ready, o_vcom, o_va, o_vb, o_rgb};
  endfunction

  // Monitor: each BCK edge during a frame carries the next scoreboard word
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_busy && o_bck != bck_prev) begin
        if (exp_q.size() == 0) check("rgb_unexpected", 32'd1, 32'd0);
        else begin
          exp_w = exp_q.pop_front();
          check("rgb_word", 32'(o_rgb), 32'(exp_w));
          $display("word out rgb=%02h expected=%02h", o_rgb, exp_w);
        end
      end
      if (o_gck != gck_prev) gck_changes++;
      if (o_gen && !gen_prev) gen_pulses++;
      if (o_frame_done) done_pulses++;
      if (i_pix_valid && o_pix_ready) accepts++;
    end
    bck_prev = o_bck;
    gck_prev = o_gck;
    gen_prev = o_gen;
  end

  task automatic cyc();
    @(posedge i_clk); #1;
  endtask

  task automatic start_frame();
    i_frame_start = 1'b1;
    cyc();
    i_frame_start = 1'b0;
    check("gsp_latency", 32'(o_gsp), 32'd1);
    check("busy_set", 32'(o_busy), 32'd1);
    check("underrun_cleared", 32'(o_underrun), 32'd0);
  endtask

  task automatic feed_word(input logic [5:0] w);
    int n = 0;
    i_pix_data  = w;
    i_pix_valid = 1'b1;
    exp_q.push_back(w);
    @(negedge i_clk);
    while (!o_pix_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    check("ready_seen", 32'(o_pix_ready), 32'd1);
    cyc();
    i_pix_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge i_clk);
    while (!o_frame_done && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    check("frame_done_seen", 32'(o_frame_done), 32'd1);
    repeat (3) cyc();
  endtask

  task automatic run_frame(input int nwords, input int gap_len, input bit restart, input int exp_gen);
    int g0 = gck_changes, e0 = gen_pulses, d0 = done_pulses, a0 = accepts;
    start_frame();
    for (int i = 0; i < nwords; i++) begin
      feed_word(6'(i + 1));
      if (i == 0 && gap_len > 0) begin
        repeat (gap_len) cyc();
        check("stall_ready", 32'(o_pix_ready), 32'd1);
        check("stall_rgb_hold", 32'(o_rgb), 32'h01);
        check("stall_bck_hold", 32'(o_bck), 32'd1);
        check("stall_underrun", 32'(o_underrun), 32'd1);
      end
      if (i == 0 && restart) begin
        i_frame_start = 1'b1;
        cyc();
        i_frame_start = 1'b0;
      end
    end
    wait_done();
    check("words_accepted", 32'(accepts - a0), 32'(nwords));
    check("gck_changes", 32'(gck_changes - g0), 32'd4);
    check("gen_pulses", 32'(gen_pulses - e0), 32'(exp_gen));
    check("done_pulses", 32'(done_pulses - d0), 32'd1);
    check("gck_final", 32'(o_gck), 32'd0);
    check("busy_final", 32'(o_busy), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("underrun_final", 32'(o_underrun), 32'(gap_len > 0));
    $display("frame words=%0d gap=%0d restart=%0d gck=%0d gen=%0d underrun=%0b",
             accepts - a0, gap_len, restart, gck_changes - g0, gen_pulses - e0, o_underrun);
  endtask

  initial begin
    #1;
    check("reset_outputs", 32'(all_outputs()), 32'd0);
    repeat (2) cyc();
    i_reset = 1'b0;
    cyc();
    check("idle_busy", 32'(o_busy), 32'd0);

    // Reset landing in the middle of SHIFT
    start_frame();
    feed_word(6'h2A);
    check("pre_reset_bck", 32'(o_bck), 32'd1);
    check("pre_reset_rgb", 32'(o_rgb), 32'h2A);
    i_reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'(all_outputs()), 32'd0);
    cyc();
    i_reset = 1'b0;
    exp_q.delete();
    cyc();
    check("post_reset_busy", 32'(o_busy), 32'd0);
    $display("reset mid-shift outputs=%05h", all_outputs());

    run_frame(4, 0, 1'b0, 2);
    run_frame(4, 5, 1'b0, 2);
    run_frame(4, 0, 1'b1, 2);

    // VCOM toggler
    begin
      logic prev_vcom = 1'b0;
      int toggles = 0;
      i_vcom_en = 1'b1;
      for (int i = 1; i <= 20; i++) begin
        cyc();
        check("va_inverse", 32'(o_va), 32'(!o_vcom));
        check("vb_follow", 32'(o_vb), 32'(o_vcom));
        if (i == 3) check("vcom_before_first", 32'(o_vcom), 32'd0);
        if (i == 4) check("vcom_first_toggle", 32'(o_vcom), 32'd1);
        if (o_vcom != prev_vcom) toggles++;
        prev_vcom = o_vcom;
      end
      check("vcom_toggles", 32'(toggles), 32'd5);
      i_vcom_en = 1'b0;
      cyc();
      check("vcom_disabled", 32'({o_vcom, o_va, o_vb}), 32'd0);
      $display("vcom toggles=%0d disabled=%03b", toggles, {o_vcom, o_va, o_vb});
    end

`ifdef MEMLCD_PARTIAL_EN
    i_first_line = LW'(1);
    i_num_lines  = LW'(1);
    run_frame(2, 0, 1'b0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
